// File: rtl/issue_scheduler_if.sv
// Fetch-side, scoreboard-side and issue-side signals of the issue scheduler.
// Handshake: fetch offers entries with in_valid0/1. The entries are taken on the rising edge when in_ready is high and flush is low.
interface issue_scheduler_if #(
  parameter int PAYLOAD_W = 64
);
  logic                 in_valid0;
  logic                 in_valid1;
  logic [PAYLOAD_W-1:0] in_payload0;
  logic [PAYLOAD_W-1:0] in_payload1;
  logic                 in_is_mem0;
  logic                 in_is_mem1;
  logic                 in_is_branch0;
  logic                 in_is_branch1;
  logic                 in_ready;
  logic                 flush;
  logic                 raw_hazard0;
  logic                 raw_hazard1;
  logic                 waw_hazard0;
  logic                 waw_hazard1;
  logic                 head0_valid;
  logic                 head1_valid;
  logic [PAYLOAD_W-1:0] head0_payload;
  logic [PAYLOAD_W-1:0] head1_payload;
  logic                 head0_is_mem;
  logic                 head0_is_branch;
  logic                 head1_is_mem;
  logic                 head1_is_branch;
  logic                 issue0;
  logic                 issue1;
  logic [31:0]          stall_cycles;
  logic [31:0]          dual_issue_cycles;

  modport master (
    output in_valid0, in_valid1, in_payload0, in_payload1,
           in_is_mem0, in_is_mem1, in_is_branch0, in_is_branch1,
           flush, raw_hazard0, raw_hazard1, waw_hazard0, waw_hazard1,
    input  in_ready, head0_valid, head1_valid, head0_payload, head1_payload,
           head0_is_mem, head0_is_branch, head1_is_mem, head1_is_branch,
           issue0, issue1, stall_cycles, dual_issue_cycles
  );

  modport slave (
    input  in_valid0, in_valid1, in_payload0, in_payload1,
           in_is_mem0, in_is_mem1, in_is_branch0, in_is_branch1,
           flush, raw_hazard0, raw_hazard1, waw_hazard0, waw_hazard1,
    output in_ready, head0_valid, head1_valid, head0_payload, head1_payload,
           head0_is_mem, head0_is_branch, head1_is_mem, head1_is_branch,
           issue0, issue1, stall_cycles, dual_issue_cycles
  );
endinterface

// File: rtl/issue_scheduler.sv
// Dual-issue in-order scheduler: a circular instruction queue that is filled two-wide from fetch.
// It issues head0/head1 in the same cycle, gated by hazard flags and by the slot-pairing rules.
module issue_scheduler #(
  parameter int PAYLOAD_W = 64,
  parameter int DEPTH     = 4
) (
  input logic              clk,
  input logic              rst,
  issue_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 is_mem;
    logic                 is_branch;
  } entry_t;

  entry_t        queue_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   stall_q, stall_d;
  logic [31:0]   dual_q, dual_d;

  logic [AW-1:0] rd_ptr1, wr_ptr1;
  entry_t        head0, head1, in_entry0, in_entry1;
  logic          head0_valid, head1_valid;
  logic          issue0, issue1, ready;
  logic          enq0, enq1, stall_inc;
  logic [1:0]    enq_n, deq_n;

  // Pointers are exactly AW bits wide, so the +1 wraps modulo DEPTH.
  assign rd_ptr1 = rd_ptr_q + AW'(1);
  assign wr_ptr1 = wr_ptr_q + AW'(1);

  assign head0       = queue_q[rd_ptr_q];
  assign head1       = queue_q[rd_ptr1];
  assign head0_valid = (count_q != '0);
  assign head1_valid = (count_q >= CW'(2));

  // Readiness uses only the registered count, so fetch never sees a combinational path from the hazard inputs.
  assign ready = (count_q <= CW'(DEPTH - 2));

  assign in_entry0 = '{payload: bus.in_payload0, is_mem: bus.in_is_mem0, is_branch: bus.in_is_branch0};
  assign in_entry1 = '{payload: bus.in_payload1, is_mem: bus.in_is_mem1, is_branch: bus.in_is_branch1};

  always_comb begin
    issue0    = 1'b0;
    issue1    = 1'b0;
    enq0      = 1'b0;
    enq1      = 1'b0;
    stall_inc = 1'b0;

    issue0 = head0_valid & ~bus.raw_hazard0 & ~bus.waw_hazard0 & ~bus.flush;
    // Slot1 only pairs with slot0: no two memory ops, and no branch in either slot.
    issue1 = issue0 & head1_valid & ~bus.raw_hazard1 & ~bus.waw_hazard1
           & ~(head0.is_mem & head1.is_mem) & ~head0.is_branch & ~head1.is_branch;

    enq0      = ready & ~bus.flush & bus.in_valid0;
    enq1      = enq0 & bus.in_valid1;
    stall_inc = head0_valid & ~issue0 & ~bus.flush;
  end

  assign enq_n = {1'b0, enq0} + {1'b0, enq1};
  assign deq_n = {1'b0, issue0} + {1'b0, issue1};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    dual_d   = dual_q;

    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(deq_n);
      wr_ptr_d = wr_ptr_q + AW'(enq_n);
      count_d  = count_q + CW'(enq_n) - CW'(deq_n);
    end

    if (stall_inc && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    if (issue1 && (dual_q != 32'hFFFF_FFFF)) begin
      dual_d = dual_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
      dual_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      dual_q   <= dual_d;
    end
  end

  // Storage has no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (enq0) begin
      queue_q[wr_ptr_q] <= in_entry0;
    end
    if (enq1) begin
      queue_q[wr_ptr1] <= in_entry1;
    end
  end

  assign bus.in_ready          = ready;
  assign bus.head0_valid       = head0_valid;
  assign bus.head1_valid       = head1_valid;
  assign bus.head0_payload     = head0.payload;
  assign bus.head1_payload     = head1.payload;
  assign bus.head0_is_mem      = head0.is_mem;
  assign bus.head0_is_branch   = head0.is_branch;
  assign bus.head1_is_mem      = head1.is_mem;
  assign bus.head1_is_branch   = head1.is_branch;
  assign bus.issue0            = issue0;
  assign bus.issue1            = issue1;
  assign bus.stall_cycles      = stall_q;
  assign bus.dual_issue_cycles = dual_q;
endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter PAYLOAD_W, default 64, meaning width of one queued instruction payload ({pc, instr}).
REQ-002 Parameter DEPTH, default 4, meaning instruction-queue entries; fixed power of two, at least 4.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid0, in_valid1  in  1 each  fetch offers instruction 0 (older) and instruction 1 (younger).
REQ-006 in_payload0, in_payload1  in  PAYLOAD_W each  fetched instruction payloads.
REQ-007 in_is_mem0/1, in_is_branch0/1  in  1 each  predecoded class bits, queued with the payloads.
REQ-008 in_ready  out  1  queue accepts up to two instructions this cycle.
REQ-009 flush  in  1  redirect; discard all queued instructions.
REQ-010 raw_hazard0/1, waw_hazard0/1  in  1 each  scoreboard hazard flags, evaluated on the current head0/head1 entries.
REQ-011 head0_valid, head1_valid  out  1 each  queue entry at head (slot0) and head+1 (slot1) present.
REQ-012 head0_payload, head1_payload  out  PAYLOAD_W each  payloads of those entries.
REQ-013 head0_is_mem/is_branch, head1_is_mem/is_branch  out  1 each  class bits of those entries.
REQ-014 issue0, issue1  out  1 each  slot issues this cycle; also drive the scoreboard issue inputs.
REQ-015 stall_cycles, dual_issue_cycles  out  32 each  performance counters.

Function
REQ-016 Queue is a circular buffer: read pointer, write pointer and occupancy count; pointers wrap modulo DEPTH.
REQ-017 in_ready SHALL be 1 when count <= DEPTH-2, computed from the registered count only, not the same-cycle dequeue.
REQ-018 When in_ready is 1 and not flushing, in_valid0 enqueues entry 0; in_valid1 enqueues entry 1 behind it only if in_valid0 is also 1. in_valid1 alone is ignored.
REQ-019 head0 is the entry at the read pointer, valid when count >= 1; head1 is the entry at read pointer+1 (wrapped), valid when count >= 2.
REQ-020 issue0 = head0_valid & ~raw_hazard0 & ~waw_hazard0 & ~flush.
REQ-021 issue1 = issue0 & head1_valid & ~raw_hazard1 & ~waw_hazard1 & ~(head0_is_mem & head1_is_mem) & ~head0_is_branch & ~head1_is_branch.
REQ-022 issue1 never asserts without issue0; issue is strictly in order.
REQ-023 Dequeue count per cycle = issue0 + issue1; the read pointer advances by that amount.
REQ-024 Next count = count + enqueued - dequeued. Simultaneous enqueue and dequeue are both applied in the same cycle.
REQ-025 flush: issue0 = issue1 = 0, same-cycle enqueue is dropped, and on the next edge the pointers and count are 0; queue empty the following cycle.
REQ-026 Empty queue: head0_valid = head1_valid = 0, issue0 = issue1 = 0, payload outputs hold the entry at the read pointer (don't-care).
REQ-027 Full queue (count = DEPTH): in_ready = 0; issue and dequeue continue normally.
REQ-028 Issue outputs are combinational from registered queue state plus hazard and flush inputs (zero-cycle issue latency). An enqueued instruction is first issuable the cycle after the enqueue edge.
REQ-029 stall_cycles increments when head0_valid & ~issue0 & ~flush; it saturates at 32'hFFFFFFFF.
REQ-030 dual_issue_cycles increments when issue1 = 1; it saturates at 32'hFFFFFFFF.
REQ-031 Queue storage contents are not reset; only the pointers, count and counters are.

Reset
REQ-032 While rst is high: pointers = 0, count = 0, in_ready = 1, head0_valid = head1_valid = 0, issue0 = issue1 = 0, and both counters = 0.
REQ-033 rst asserted mid-operation discards all queued instructions immediately (asynchronously), with no issue afterward until new enqueues arrive.

Verification
REQ-034 Reset, then enqueue A (ALU) and B (ALU), no hazards -> next cycle issue0 = issue1 = 1, dual_issue_cycles = 1, and the queue is empty after.
REQ-035 Enqueue LW, SW (both is_mem) -> cycle 1: issue0 = 1, issue1 = 0; cycle 2: SW is at head0, issue0 = 1.
REQ-036 head0 with raw_hazard0 = 1 for 3 cycles -> issue0 = issue1 = 0 and stall_cycles = 3; head1 is not issued even if hazard-free.
REQ-037 Fill to count = 4 with hazards held -> in_ready = 0 and further in_valid is ignored; release the hazards -> entries issue in FIFO order across the pointer wrap.
REQ-038 With 3 entries queued, assert flush together with in_valid0 = 1 -> no issue, next cycle count = 0 and head0_valid = 0.
REQ-039 Branch at head1 with clean hazards -> issue0 = 1, issue1 = 0; the next cycle the branch is at head0 and issue0 = 1.
